boot_loadable_rom: RTL

Parametrised instruction ROM for the Hack computer that can be reloaded at run time from a byte stream: a boot loader or UART feeds bytes in, they are packed into words and written sequentially from address 0. The block sits between the loader and the CPU instruction-fetch port. `loading` holds the CPU off while an image is being written. Outside a load it behaves as a combinational-read instruction ROM.

---
 rtl/boot_rom_pkg.sv | 8 +
 rtl/rom_byte_assembler.sv | 38 +++
 rtl/boot_loadable_rom.sv | 104 ++++++++++
 3 files changed

// File: rtl/boot_rom_pkg.sv
// boot_rom_pkg: shared FSM state type, bytes-per-word helper and checksum width for the boot-loadable ROM.
package boot_rom_pkg;
   typedef enum logic [1:0] {IDLE, RECV, DONE} state_e;
   localparam int CSUM_W = 16;
   function automatic int bpw(input int dw);
      return dw / 8;
   endfunction
endpackage

// File: rtl/rom_byte_assembler.sv
// rom_byte_assembler: packs an MSB-first byte stream into DATA_WIDTH-bit words.
// Ports: clk, rst_n (sync active-low), clr (holds the assembly empty), byte_en (byte accepted),
//        byte_data (incoming byte), word_valid (high on the accepting edge of a word's last byte),
//        word (assembled word including the current byte).
module rom_byte_assembler
   import boot_rom_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  byte_en,
   input  logic [7:0]            byte_data,
   output logic                  word_valid,
   output logic [DATA_WIDTH-1:0] word
);
   localparam int BPW = bpw(DATA_WIDTH);
   localparam int CW  = BPW > 1 ? $clog2(BPW) : 1;
   logic [DATA_WIDTH-1:0] sh_q;
   logic [CW-1:0]         cnt_q;
   logic                  last;
   // word is combinational so the top can write it on the same edge the last byte arrives
   always_comb begin
      last       = cnt_q == CW'(BPW - 1);
      word       = (sh_q << 8) | DATA_WIDTH'(byte_data);
      word_valid = byte_en && last;
   end
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         sh_q  <= '0;
         cnt_q <= '0;
      end else if (byte_en) begin
         sh_q  <= word;
         cnt_q <= last ? '0 : cnt_q + CW'(1);
      end
   end
endmodule

// File: rtl/boot_loadable_rom.sv
// boot_loadable_rom: combinational-read instruction ROM reloadable at run time from a byte stream.
// Ports: clk, rst_n (sync active-low); address/out (fetch port, out=0 while loading);
//        load_start/load_len (begin a load of load_len words, clamped to the depth);
//        byte_valid/byte_data/byte_ready (byte stream, MSB of each word first);
//        loading (CPU hold-off), load_done (one-cycle completion pulse), checksum (16-bit word sum).
// Build option: BOOT_ROM_CHECKSUM_EN builds the checksum accumulator; otherwise checksum is 0.
module boot_loadable_rom
   import boot_rom_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] out,
   input  logic                  load_start,
   input  logic [ADDR_WIDTH:0]   load_len,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  loading,
   output logic                  load_done,
   output logic [CSUM_W-1:0]     checksum
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
   state_e                state_q;
   logic [ADDR_WIDTH:0]   len_q, len_d, wcnt_q, wcnt_d;
   logic                  loading_q, done_q, word_valid;
   logic [DATA_WIDTH-1:0] word;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   rom_byte_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (!loading_q),
      .byte_en   (byte_valid && loading_q),
      .byte_data (byte_data),
      .word_valid(word_valid),
      .word      (word)
   );
   always_comb begin
      len_d      = load_len > DEPTH_L ? DEPTH_L : load_len;
      wcnt_d     = wcnt_q + 1'b1;
      out        = loading_q ? '0 : mem[address];
      byte_ready = loading_q;
      loading    = loading_q;
      load_done  = done_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         len_q     <= '0;
         wcnt_q    <= '0;
         loading_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (load_start) begin
               len_q     <= len_d;
               wcnt_q    <= '0;
               state_q   <= len_d == '0 ? DONE : RECV;
               loading_q <= len_d != '0;
               done_q    <= len_d == '0;
            end
            RECV: if (word_valid) begin
               wcnt_q <= wcnt_d;
               if (wcnt_d == len_q) begin
                  state_q   <= DONE;
                  loading_q <= 1'b0;
                  done_q    <= 1'b1;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   // len is clamped to DEPTH and the load stops at len, so the low bits never wrap
   always_ff @(posedge clk) begin
      if (rst_n && word_valid) mem[wcnt_q[ADDR_WIDTH-1:0]] <= word;
   end
`ifdef BOOT_ROM_CHECKSUM_EN
   localparam int NSL = (DATA_WIDTH + CSUM_W - 1) / CSUM_W;
   logic [NSL*CSUM_W-1:0] wide;
   logic [CSUM_W-1:0]     wsum, csum_q;
   // wide words contribute as a sum of their 16-bit slices
   always_comb begin
      wide = (NSL * CSUM_W)'(word);
      wsum = '0;
      for (int i = 0; i < NSL; i++) wsum = wsum + wide[i*CSUM_W +: CSUM_W];
   end
   always_ff @(posedge clk) begin
      if (!rst_n || (state_q == IDLE && load_start)) csum_q <= '0;
      else if (word_valid) csum_q <= csum_q + wsum;
   end
   assign checksum = csum_q;
`else
   assign checksum = '0;
`endif
endmodule
